// File: rtl/pad_link_pkg.sv
// Shared types and defaults for the serial gamepad link responder.
// Contents: FSM state enum, default parameter values, idle level of the data line.
package pad_link_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLatched,
        StShift,
        StDone
    } pad_state_e;

    localparam int unsigned NBITS_DEFAULT          = 16;
    localparam int unsigned SYNC_STAGES_DEFAULT    = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 4096;

    // Level of pad_data when no button is reported (the line is active-low).
    localparam logic PAD_RELEASED = 1'b1;

endpackage

// File: rtl/pad_link_if.sv
// Pad-link bundle between the host side (latch/clock/button sources) and the responder.
// master: drives pad_latch, pad_clk, buttons (and turbo_mask when PAD_LINK_TURBO_EN is defined);
//         observes pad_data, busy, frame_done, timeout_err, poll_count.
// slave : the responder, with the opposite directions.
interface pad_link_if #(
    parameter int unsigned NBITS = 16
);
    logic             pad_latch;
    logic             pad_clk;
    logic [NBITS-1:0] buttons;
    logic             pad_data;
    logic             busy;
    logic             frame_done;
    logic             timeout_err;
    logic [15:0]      poll_count;
`ifdef PAD_LINK_TURBO_EN
    logic [NBITS-1:0] turbo_mask;

    modport master (
        output pad_latch, pad_clk, buttons, turbo_mask,
        input  pad_data, busy, frame_done, timeout_err, poll_count
    );
    modport slave (
        input  pad_latch, pad_clk, buttons, turbo_mask,
        output pad_data, busy, frame_done, timeout_err, poll_count
    );
`else
    modport master (
        output pad_latch, pad_clk, buttons,
        input  pad_data, busy, frame_done, timeout_err, poll_count
    );
    modport slave (
        input  pad_latch, pad_clk, buttons,
        output pad_data, busy, frame_done, timeout_err, poll_count
    );
`endif
endinterface

// File: rtl/pad_link_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous host pin.
// Ports: clock, reset_btn (sync, active-low), pin_i (async pin),
//        rise_o / fall_o (one-cycle pulses, valid SYNC_STAGES cycles after the pin edge).
// SYNC_STAGES must be at least 2.
module pad_link_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_btn,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Combinational edges so the consuming FSM acts on the very next clock edge.
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/pad_link_responder.sv
// Emulated shift-register gamepad: host latches, then clocks out one active-low bit per rise.
// Ports: clock, reset_btn (sync, active-low), bus (pad_link_if.slave: pad_latch, pad_clk,
//        buttons, pad_data, busy, frame_done, timeout_err, poll_count).
// Optional build macro PAD_LINK_TURBO_EN adds bus.turbo_mask and a turbo phase that masks
// selected buttons as released on alternate groups of TURBO_PERIOD frames.
// NBITS must be at least 2.
module pad_link_responder
    import pad_link_pkg::*;
#(
    parameter int unsigned NBITS          = NBITS_DEFAULT,
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned TURBO_PERIOD   = 4
) (
    input logic       clock,
    input logic       reset_btn,
    pad_link_if.slave bus
);
    localparam int unsigned CntW = $clog2(NBITS + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic latch_rise, latch_fall, clk_rise, unused_clk_fall;

    pad_link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clock     (clock),
        .reset_btn (reset_btn),
        .pin_i     (bus.pad_latch),
        .rise_o    (latch_rise),
        .fall_o    (latch_fall)
    );

    pad_link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clock     (clock),
        .reset_btn (reset_btn),
        .pin_i     (bus.pad_clk),
        .rise_o    (clk_rise),
        .fall_o    (unused_clk_fall)
    );

    pad_state_e       state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [15:0]      poll_q, poll_d;
    logic             frame_done_q, frame_done_d;
    logic             timeout_q, timeout_d;
    logic [NBITS-1:0] load_val;
    logic             pad_data;

`ifdef PAD_LINK_TURBO_EN
    localparam int unsigned TurboW = $clog2(TURBO_PERIOD + 1);
    logic              phase_q;
    logic [TurboW-1:0] turbo_cnt_q;

    // Phase advances once per TURBO_PERIOD completed frames.
    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            phase_q     <= 1'b0;
            turbo_cnt_q <= '0;
        end else if (frame_done_d) begin
            if (turbo_cnt_q == TurboW'(TURBO_PERIOD - 1)) begin
                turbo_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                turbo_cnt_q <= turbo_cnt_q + TurboW'(1);
            end
        end
    end

    assign load_val = ~(bus.buttons & ~(phase_q ? bus.turbo_mask : '0));
`else
    localparam int unsigned unused_turbo_period = TURBO_PERIOD;
    assign load_val = ~bus.buttons;
`endif

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_d        = tmo_q;
        poll_d       = poll_q;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;
        // Latch rise wins over everything, including a same-cycle clock rise.
        if (latch_rise) begin
            state_d   = StLatched;
            shreg_d   = load_val;
            bit_cnt_d = '0;
            tmo_d     = '0;
        end else begin
            unique case (state_q)
                StLatched: begin
                    shreg_d = load_val;
                    if (latch_fall) begin
                        state_d   = StShift;
                        bit_cnt_d = '0;
                        tmo_d     = '0;
                    end
                end
                StShift: begin
                    if (clk_rise) begin
                        shreg_d   = {PAD_RELEASED, shreg_q[NBITS-1:1]};
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                        tmo_d     = '0;
                        if (bit_cnt_q == CntW'(NBITS - 1)) begin
                            state_d      = StDone;
                            frame_done_d = 1'b1;
                            poll_d       = poll_q + 16'd1;
                        end
                    end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = StIdle;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                    end
                end
                StIdle, StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            poll_q       <= '0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            poll_q       <= poll_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
        end
    end

    // While latched the line follows the live buttons (transparent load).
    always_comb begin
        pad_data = PAD_RELEASED;
        unique case (state_q)
            StLatched: pad_data = load_val[0];
            StShift:   pad_data = shreg_q[0];
            default:   pad_data = PAD_RELEASED;
        endcase
    end

    assign bus.pad_data    = pad_data;
    assign bus.busy        = (state_q == StLatched) || (state_q == StShift);
    assign bus.frame_done  = frame_done_q;
    assign bus.timeout_err = timeout_q;
    assign bus.poll_count  = poll_q;

endmodule
